// File: rtl/gsdiv_pkg.sv
// Shared constants for the Q9.23 Goldschmidt divider sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gsdiv_pkg;

    // Q9.23 unsigned fixed point: 9 integer bits, 23 fraction bits
    localparam int Q_W    = 32;
    localparam int Q_INT  = 9;
    localparam int Q_FRAC = 23;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Result returned for a zero divisor
    localparam logic [Q_W-1:0] DIV_ZERO_SAT = '1;

endpackage

// File: rtl/gsdiv_ctrl.sv
// Sequencer for the iterative Q9.23 Goldschmidt divider (optional macro: GSDIV_CTRL_CONVERGE_EN enables early stop on convergence).
// Latency: result 2+n cycles after accept (n = iterations, 1..MAX_ITER); zero divisor answered the cycle after accept.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, nothing new accepted meanwhile.
import gsdiv_pkg::*;

module gsdiv_ctrl #(
    parameter int W        = Q_W,
    parameter int MAX_ITER = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         div_start,
    output logic         div_stop,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic [W-1:0] div_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic         div_by_zero,
    output logic [3:0]   iter_count
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] iter;
    logic       accept;
    logic       conv_hit;
    logic       terminate;
    logic       divisor_zero;

`ifdef GSDIV_CTRL_CONVERGE_EN
    logic [W-1:0] prev;
    // Two matching consecutive estimates mean the divider has settled
    assign conv_hit = (iter != 4'd0) && (div_out == prev);
`else
    assign conv_hit = 1'b0;
`endif

    assign accept       = (state == ST_IDLE) && in_valid && in_ready;
    assign divisor_zero = (divisor == '0);
    assign terminate    = (state == ST_ITER) &&
                          (((iter + 4'd1) == 4'(MAX_ITER)) || conv_hit);

    // Pulses and result-valid are gated by reset so an abandoned run never signals the divider or downstream
    assign div_start = (state == ST_LOAD) && !reset;
    assign div_stop  = terminate && !reset;
    assign out_valid = (state == ST_DONE) && !reset;

    // Next-state selection for the single sequencing FSM
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = divisor_zero ? ST_DONE : ST_LOAD;
            ST_LOAD: state_nxt = ST_ITER;
            ST_ITER: if (terminate) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, operand capture, iteration counting and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            iter         <= 4'd0;
            div_dividend <= '0;
            div_divisor  <= '0;
            quotient     <= '0;
            div_by_zero  <= 1'b0;
            iter_count   <= 4'd0;
`ifdef GSDIV_CTRL_CONVERGE_EN
            prev         <= '0;
`endif
        end else begin
            state    <= state_nxt;
            // Registered so it reads 0 in the first cycle after reset
            in_ready <= (state_nxt == ST_IDLE);

            if (accept) begin
                div_dividend <= dividend;
                div_divisor  <= divisor;
                iter         <= 4'd0;
                div_by_zero  <= divisor_zero;
`ifdef GSDIV_CTRL_CONVERGE_EN
                prev         <= '0;
`endif
                if (divisor_zero) begin
                    quotient   <= DIV_ZERO_SAT[W-1:0];
                    iter_count <= 4'd0;
                end
            end

            if (state == ST_LOAD) begin
                iter <= 4'd0;
            end

            if (state == ST_ITER) begin
                iter <= iter + 4'd1;
`ifdef GSDIV_CTRL_CONVERGE_EN
                prev <= div_out;
`endif
                if (terminate) begin
                    quotient   <= div_out;
                    iter_count <= iter + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsdiv_ctrl.sv
// Self-checking bench for gsdiv_ctrl with a behavioural divider and result model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and busy-time in_valid.
module tb_gsdiv_ctrl;

    localparam int W        = 32;
    localparam int MAX_ITER = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         div_start;
    logic         div_stop;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic [W-1:0] div_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic         div_by_zero;
    logic [3:0]   iter_count;

    always #5 clk = ~clk;

    gsdiv_ctrl #(.W(W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .div_start(div_start), .div_stop(div_stop),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_out(div_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .div_by_zero(div_by_zero), .iter_count(iter_count)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural divider ----------------
    // Estimate k (k-th cycle after the start pulse) approaches the exact quotient,
    // reaching it at step cur_c and staying there.
    logic [31:0] cur_q = 32'd0;
    int          cur_c = 0;
    int          kk    = 1000;
    logic        start_seen = 1'b0;

    always @(negedge clk) start_seen <= div_start;
    always @(posedge clk) begin
        if (start_seen) kk <= 0;
        else            kk <= kk + 1;
    end
    assign div_out = (kk >= cur_c) ? cur_q : cur_q - 32'(cur_c - kk);

    function automatic logic [31:0] exact_q(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] q64;
        q64 = ({32'd0, a} << 23) / {32'd0, b};
        return (q64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q64[31:0];
    endfunction

    // ---------------- expected result model ----------------
    logic [31:0] exp_q;
    logic        exp_dbz;
    logic [3:0]  exp_n;
    int          exp_lat;

    task automatic set_model(input logic [31:0] a, input logic [31:0] b, input int c);
        int nn;
        cur_c = c;
        if (b == 32'd0) begin
            cur_q   = 32'd0;
            exp_q   = 32'hFFFF_FFFF;
            exp_dbz = 1'b1;
            exp_n   = 4'd0;
            exp_lat = 1;
        end else begin
            cur_q   = exact_q(a, b);
            exp_dbz = 1'b0;
            nn      = MAX_ITER;
`ifdef GSDIV_CTRL_CONVERGE_EN
            // first repeat of the settled value is seen one step after it appears
            if (c + 1 <= MAX_ITER - 1) nn = c + 2;
`endif
            // captured estimate is the one present on the last iteration
            exp_q   = (nn - 1 >= c) ? cur_q : cur_q - 32'(c - (nn - 1));
            exp_n   = 4'(nn);
            exp_lat = 2 + nn;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("start_stop_excl", {63'd0, div_start && div_stop}, 64'd0);
            chk("ready_valid_excl", {63'd0, in_ready && out_valid}, 64'd0);
            if (out_valid) begin
                chk("quotient", {32'd0, quotient}, {32'd0, exp_q});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dbz});
                chk("iter_count", {60'd0, iter_count}, {60'd0, exp_n});
            end
        end
    end

    logic [31:0] last_q;
    logic [3:0]  last_n;

    // One full transaction; entered and left just after a falling edge
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int c, input int hold);
        int starts, stops, held, waited;
        bit seen, done;
        logic [31:0] q0;
        logic [3:0]  n0;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        set_model(a, b, c);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        if (hold > 0) begin
            // a second request pestering while busy must be ignored
            dividend = ~a;
            divisor  = b | 32'd1;
        end else begin
            in_valid = 1'b0;
        end
        starts = 0; stops = 0; held = 0; seen = 0; done = 0;
        q0 = 32'd0; n0 = 4'd0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (div_start) begin starts++; chk("start_cycle", 64'(cyc), 64'd1); end
            if (div_stop)  begin stops++;  chk("stop_cycle", 64'(cyc), 64'(exp_lat - 1)); end
            if (cyc == 1) begin
                chk("div_dividend", {32'd0, div_dividend}, {32'd0, a});
                chk("div_divisor", {32'd0, div_divisor}, {32'd0, b});
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    chk("latency", 64'(cyc), 64'(exp_lat));
                    q0 = quotient;
                    n0 = iter_count;
                end else begin
                    chk("hold_quotient", {32'd0, quotient}, {32'd0, q0});
                    chk("hold_iter", {60'd0, iter_count}, {60'd0, n0});
                    chk("hold_operand", {32'd0, div_dividend}, {32'd0, a});
                    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
                end
                if (!out_ready) begin
                    if (held >= hold) out_ready = 1'b1;
                    else held++;
                end
                if (out_ready) begin
                    done = 1;
                    in_valid = 1'b0;
                end
            end
        end
        chk("handoff_reached", {63'd0, done}, 64'd1);
        chk("start_pulses", 64'(starts), (b == 32'd0) ? 64'd0 : 64'd1);
        chk("stop_pulses", 64'(stops), (b == 32'd0) ? 64'd0 : 64'd1);
        last_q = q0;
        last_n = n0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b0;

        // model pins against hand-computed quotients
        chk("pin_6_over_2", {32'd0, exact_q(32'h0300_0000, 32'h0100_0000)}, 64'h0180_0000);
        chk("pin_1_over_3", {32'd0, exact_q(32'h0080_0000, 32'h0180_0000)}, 64'h002A_AAAA);
        chk("pin_4_over_1", {32'd0, exact_q(32'h0200_0000, 32'h0080_0000)}, 64'h0200_0000);

        // reset state
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_div_start", {63'd0, div_start}, 64'd0);
        @(negedge clk);
        chk("rst_quotient", {32'd0, quotient}, 64'd0);
        chk("rst_iter_count", {60'd0, iter_count}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_first_idle_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("rst_ready_after", {63'd0, in_ready}, 64'd1);

        // 6.0 / 2.0
        run(32'h0300_0000, 32'h0100_0000, 0, 0);
        chk("dir_6_2_q", {32'd0, last_q}, 64'h0180_0000);

        // divide by zero
        run(32'h0123_4567, 32'h0000_0000, 0, 0);
        chk("dir_dbz_q", {32'd0, last_q}, 64'hFFFF_FFFF);
        chk("dir_dbz_n", {60'd0, last_n}, 64'd0);

        // 1.0 / 3.0
        run(32'h0080_0000, 32'h0180_0000, 2, 0);
        chk("dir_1_3_q", {32'd0, last_q}, 64'h002A_AAAA);
`ifdef GSDIV_CTRL_CONVERGE_EN
        chk("dir_1_3_n", {60'd0, last_n}, 64'd4);
`else
        chk("dir_1_3_n", {60'd0, last_n}, 64'd6);
`endif

        // downstream stall for 5 cycles with a competing request
        run(32'h0500_0000, 32'h0080_0000, 1, 5);
        chk("dir_stall_q", {32'd0, last_q}, 64'h0500_0000);

        // 4.0 / 1.0 with an immediately settled divider
        run(32'h0200_0000, 32'h0080_0000, 0, 0);
        chk("dir_4_1_q", {32'd0, last_q}, 64'h0200_0000);
`ifdef GSDIV_CTRL_CONVERGE_EN
        chk("dir_4_1_early", {63'd0, (last_n < 4'd6)}, 64'd1);
`else
        chk("dir_4_1_n", {60'd0, last_n}, 64'd6);
`endif

        // reset during the third iteration cycle
        set_model(32'h0300_0000, 32'h0100_0000, 7);
        dividend = 32'h0300_0000; divisor = 32'h0100_0000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_no_stop", {63'd0, div_stop}, 64'd0);
        chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_quotient", {32'd0, quotient}, 64'd0);
        chk("abort_iter", {60'd0, iter_count}, 64'd0);
        chk("abort_dd", {32'd0, div_dividend}, 64'd0);
        chk("abort_dv", {32'd0, div_divisor}, 64'd0);
        chk("abort_pulses", {62'd0, div_start, div_stop}, 64'd0);
        @(negedge clk);
        chk("abort_ready_after", {63'd0, in_ready}, 64'd1);
        run(32'h0300_0000, 32'h0100_0000, 0, 0);
        chk("abort_rerun_q", {32'd0, last_q}, 64'h0180_0000);

        // randomized traffic
        for (int t = 0; t < 25; t++) begin
            ra = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            else begin
                rb = $urandom >> $urandom_range(0, 28);
                if (rb == 32'd0) rb = 32'd1;
            end
            run(ra, rb, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gsdiv_ctrl.md
# gsdiv_ctrl

Sequencer for the iterative Q9.23 Goldschmidt divider datapath: accepts operand pairs over a valid/ready handshake, drives the divider's start/stop interface, counts refinement iterations, detects convergence, and returns the captured quotient over a valid/ready handshake. It sits between the upstream arithmetic pipeline and the divider, as the initiator end of the divider's start/stop/out interface. Divide-by-zero is intercepted here and never reaches the divider.

## Interface
- W, 32, operand/result width (Q9.23: 9 integer, 23 fraction bits, unsigned)
- MAX_ITER, 6, maximum refinement cycles per division (≥2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands
- dividend  in  W  Q9.23 numerator
- divisor  in  W  Q9.23 denominator
- div_start  out  1  one-cycle load pulse to divider
- div_stop  out  1  one-cycle freeze pulse to divider
- div_dividend  out  W  registered dividend to divider
- div_divisor  out  W  registered divisor to divider
- div_out  in  W  divider's current quotient estimate
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- quotient  out  W  captured Q9.23 result
- div_by_zero  out  1  result is from a zero divisor; valid with out_valid
- iter_count  out  4  iterations used for current result; valid with out_valid

## Operation
- States: IDLE, LOAD, ITER, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: register dividend/divisor, clear iter/prev. Divisor==0 → DONE directly with quotient=all-ones, div_by_zero=1, iter_count=0. Otherwise → LOAD.
- LOAD: div_start=1 for exactly this cycle; div_dividend/div_divisor stable from register → ITER, iter=0.
- ITER: each cycle iter+=1, prev<=div_out. Terminate when (iter+1)==MAX_ITER, or (macro on) iter≥1 and div_out==prev. On terminate: quotient<=div_out, iter_count<=iter+1, div_stop=1 this cycle, → DONE.
- DONE: out_valid=1, quotient/div_by_zero/iter_count held stable. On out_ready → IDLE.
- in_ready=1 only in IDLE; no operand acceptance in same cycle as result handoff.
- div_start and div_stop never both 1; neither asserted outside LOAD/ITER.
- Reset: state IDLE; in_ready=0 during reset cycle, 1 after; out_valid, div_start, div_stop, div_by_zero=0; quotient, div_dividend, div_divisor, iter_count=0.
- Reset mid-ITER: abandon operation, no div_stop pulse, no out_valid; divider is reset by its own reset.

## Timing
- Accept edge T → LOAD in T+1 (div_start high) → first estimate on div_out during T+2.
- Result: out_valid at T+2+n, n = iterations used (1..MAX_ITER); worst case MAX_ITER+2 cycles after accept.
- Divide-by-zero: out_valid the cycle after accept.
- out_ready sampled only while out_valid=1; held low → DONE held indefinitely, outputs unchanged.
- in_valid while busy ignored; upstream must hold operands until in_ready.

## Configuration
- GSDIV_CTRL_CONVERGE_EN defined: early termination when two consecutive div_out samples match; iteration cap still applies.
- Undefined: every nonzero division runs exactly MAX_ITER iterations; iter_count always MAX_ITER; prev comparator removed.

## Structure
- Shared package gsdiv_pkg: Q9.23 width/fraction constants, state enum (IDLE, LOAD, ITER, DONE), DIV_ZERO_SAT constant (all-ones).
- No sub-module; single FSM plus registers. Divider datapath is instantiated beside this block by the parent.

## Test plan
- 0x0300_0000 / 0x0100_0000 (6.0/2.0), out_ready=1 → quotient 0x0180_0000 ±2 LSB, div_by_zero=0, div_start one pulse at T+1, one div_stop pulse.
- Divisor 0x0000_0000 → out_valid at T+1, quotient 0xFFFF_FFFF, div_by_zero=1, iter_count=0, div_start never asserted.
- Macro undefined, 1.0/3.0 (0x0080_0000/0x0180_0000) → out_valid at T+8, iter_count=6, quotient 0x002A_AAAA ±2 LSB.
- out_ready low 5 cycles in DONE → quotient, iter_count stable, in_ready=0, second in_valid not accepted until handoff.
- reset asserted in 3rd ITER cycle → next cycle IDLE, all outputs zero, in_ready=1 following cycle; new 6.0/2.0 completes correctly.
- Macro defined, 4.0/1.0 → terminates before MAX_ITER, iter_count<6, quotient 0x0200_0000.
